// File: rtl/pc_sequencer.sv
// Run-control sequencer for the fetch pipeline: takes LOAD/RUN/STEP/ABORT commands and
// drives the PC enable/advance flags, counting every cycle in which the PC advances.
module pc_sequencer #(
    parameter int SIZE_CYCLE = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    input  logic [1:0]            i_cmd,
    output logic                  o_cmd_ready,
    input  logic                  i_load_done,
    input  logic                  i_flag_halt,
    input  logic                  i_stall,
    output logic                  o_enable,
    output logic                  o_flag_start_pc,
    output logic                  o_flag_load_pc,
    output logic [2:0]            o_state,
    output logic [SIZE_CYCLE-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_ABORT = 2'b11
    } cmd_t;

    state_t                state_q, state_d;
    logic                  enable_q;
    logic [SIZE_CYCLE-1:0] count_q, count_d;
    cmd_t                  cmd_w;
    logic                  abort_w;
    logic                  accept_w;
    logic                  load_accept_w;

    assign cmd_w         = cmd_t'(i_cmd);
    // ABORT bypasses the ready handshake so it can break out of any state.
    assign abort_w       = i_cmd_valid && (cmd_w == CMD_ABORT);
    assign o_cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_HALTED);
    assign accept_w      = i_cmd_valid && o_cmd_ready && !abort_w;
    assign load_accept_w = accept_w && (cmd_w == CMD_LOAD);

    assign o_enable        = enable_q;
    assign o_flag_start_pc = enable_q && !i_stall && !i_flag_halt;
    assign o_flag_load_pc  = !o_flag_start_pc;
    assign o_state         = state_q;
    assign o_cycle_count   = count_q;

    always_comb begin
        // NOTE: defaults assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (abort_w) begin
                    state_d = ST_IDLE;
                end else if (accept_w) begin
                    case (cmd_w)
                        CMD_LOAD: state_d = ST_LOAD;
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (abort_w || i_load_done) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (abort_w)          state_d = ST_IDLE;
                else if (i_flag_halt) state_d = ST_HALTED;
            end
            ST_STEP: begin
                if (abort_w)          state_d = ST_IDLE;
                else if (i_flag_halt) state_d = ST_HALTED;
                else                  state_d = ST_IDLE;
            end
            ST_HALTED: begin
                // RUN and STEP are consumed here but leave the sequencer halted.
                if (abort_w)            state_d = ST_IDLE;
                else if (load_accept_w) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (load_accept_w) begin
            count_d = '0;
        end else if (o_flag_start_pc && (count_q != {SIZE_CYCLE{1'b1}})) begin
            count_d = count_q + SIZE_CYCLE'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= (state_d == ST_RUN) || (state_d == ST_STEP);
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second, 3-bit-counter instance shares the stimulus
// so counter saturation can be reached in a few cycles.
module tb_pc_sequencer;

    localparam logic [1:0] C_LOAD  = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_ABORT = 2'b11;

    logic        i_clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd;
    logic        i_load_done;
    logic        i_flag_halt;
    logic        i_stall;
    logic        o_cmd_ready;
    logic        o_enable;
    logic        o_flag_start_pc;
    logic        o_flag_load_pc;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;

    logic        s_cmd_ready;
    logic        s_enable;
    logic        s_flag_start_pc;
    logic        s_flag_load_pc;
    logic [2:0]  s_state;
    logic [2:0]  s_cycle_count;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_sequencer #(.SIZE_CYCLE(32)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_cmd_valid     (i_cmd_valid),
        .i_cmd           (i_cmd),
        .o_cmd_ready     (o_cmd_ready),
        .i_load_done     (i_load_done),
        .i_flag_halt     (i_flag_halt),
        .i_stall         (i_stall),
        .o_enable        (o_enable),
        .o_flag_start_pc (o_flag_start_pc),
        .o_flag_load_pc  (o_flag_load_pc),
        .o_state         (o_state),
        .o_cycle_count   (o_cycle_count)
    );

    pc_sequencer #(.SIZE_CYCLE(3)) dut_small (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_cmd_valid     (i_cmd_valid),
        .i_cmd           (i_cmd),
        .o_cmd_ready     (s_cmd_ready),
        .i_load_done     (i_load_done),
        .i_flag_halt     (i_flag_halt),
        .i_stall         (i_stall),
        .o_enable        (s_enable),
        .o_flag_start_pc (s_flag_start_pc),
        .o_flag_load_pc  (s_flag_load_pc),
        .o_state         (s_state),
        .o_cycle_count   (s_cycle_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        step();
        i_cmd_valid = 1'b0;
    endtask

    initial begin
        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd       = C_LOAD;
        i_load_done = 1'b0;
        i_flag_halt = 1'b0;
        i_stall     = 1'b0;
        step();
        step();
        i_reset = 1'b0;

        check("rst_state",   32'(o_state), 32'd0);
        check("rst_count",   o_cycle_count, 32'd0);
        check("rst_enable",  32'(o_enable), 32'd0);
        check("rst_start",   32'(o_flag_start_pc), 32'd0);
        check("rst_load_pc", 32'(o_flag_load_pc), 32'd1);
        check("rst_ready",   32'(o_cmd_ready), 32'd1);

        // LOAD, loader completes after 5 cycles
        send(C_LOAD);
        check("load_state", 32'(o_state), 32'd1);
        check("load_ready", 32'(o_cmd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("load_enable", 32'(o_enable), 32'd0);
            step();
        end
        check("load_hold_state", 32'(o_state), 32'd1);
        i_load_done = 1'b1;
        step();
        i_load_done = 1'b0;
        check("load_done_state", 32'(o_state), 32'd0);
        check("load_done_count", o_cycle_count, 32'd0);
        check("load_done_enable", 32'(o_enable), 32'd0);

        // RUN for 10 unstalled cycles, then halt
        send(C_RUN);
        check("run_state",  32'(o_state), 32'd2);
        check("run_enable", 32'(o_enable), 32'd1);
        check("run_start",  32'(o_flag_start_pc), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 6) check("sat_reach", 32'(s_cycle_count), 32'd7);
        end
        check("run_count10", o_cycle_count, 32'd10);
        check("sat_hold",    32'(s_cycle_count), 32'd7);
        i_flag_halt = 1'b1;
        #1;
        check("halt_start_pc", 32'(o_flag_start_pc), 32'd0);
        step();
        i_flag_halt = 1'b0;
        check("halted_state",  32'(o_state), 32'd4);
        check("halted_enable", 32'(o_enable), 32'd0);
        check("halted_ready",  32'(o_cmd_ready), 32'd1);
        check("halted_count",  o_cycle_count, 32'd10);
        check("sat_after",     32'(s_cycle_count), 32'd7);

        // HALTED discards RUN/STEP; ABORT beats halt; LOAD clears count; ABORT beats load_done
        send(C_RUN);
        check("halted_run_ignored",  32'(o_state), 32'd4);
        send(C_STEP);
        check("halted_step_ignored", 32'(o_state), 32'd4);
        i_flag_halt = 1'b1;
        send(C_ABORT);
        i_flag_halt = 1'b0;
        check("abort_vs_halt", 32'(o_state), 32'd0);
        send(C_LOAD);
        check("reload_state", 32'(o_state), 32'd1);
        check("reload_count", o_cycle_count, 32'd0);
        i_load_done = 1'b1;
        send(C_ABORT);
        i_load_done = 1'b0;
        check("abort_vs_done", 32'(o_state), 32'd0);

        // RUN for 8 cycles with stalls in cycles 1, 3 and 4
        send(C_RUN);
        for (int i = 0; i < 8; i++) begin
            i_stall = (i == 1) || (i == 3) || (i == 4);
            #1;
            check("stall_load_pc", 32'(o_flag_load_pc), 32'(i_stall));
            step();
        end
        check("stall_count", o_cycle_count, 32'd5);
        i_stall = 1'b1;
        send(C_ABORT);
        i_stall = 1'b0;
        check("abort_run_state", 32'(o_state), 32'd0);
        check("abort_run_count", o_cycle_count, 32'd5);

        // Two single steps separated by idle cycles
        send(C_LOAD);
        i_load_done = 1'b1;
        step();
        i_load_done = 1'b0;
        check("step_pre_count", o_cycle_count, 32'd0);
        send(C_STEP);
        check("step1_state",  32'(o_state), 32'd3);
        check("step1_enable", 32'(o_enable), 32'd1);
        step();
        check("step1_back",   32'(o_state), 32'd0);
        check("step1_en_off", 32'(o_enable), 32'd0);
        check("step1_count",  o_cycle_count, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_enable", 32'(o_enable), 32'd0);
        end
        send(C_STEP);
        check("step2_enable", 32'(o_enable), 32'd1);
        step();
        check("step2_back",  32'(o_state), 32'd0);
        check("step2_count", o_cycle_count, 32'd2);

        // Stalled step ends after one cycle without advancing
        send(C_STEP);
        i_stall = 1'b1;
        #1;
        check("step_stall_start", 32'(o_flag_start_pc), 32'd0);
        step();
        i_stall = 1'b0;
        check("step_stall_state", 32'(o_state), 32'd0);
        check("step_stall_count", o_cycle_count, 32'd2);

        // Halt during a step goes to HALTED
        send(C_STEP);
        i_flag_halt = 1'b1;
        step();
        i_flag_halt = 1'b0;
        check("step_halt_state", 32'(o_state), 32'd4);
        check("step_halt_count", o_cycle_count, 32'd2);

        // Reset mid-RUN overrides a simultaneous command
        send(C_ABORT);
        send(C_RUN);
        step();
        step();
        step();
        check("pre_reset_count", o_cycle_count, 32'd5);
        i_reset     = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd       = C_RUN;
        step();
        i_reset     = 1'b0;
        i_cmd_valid = 1'b0;
        check("mid_rst_state",   32'(o_state), 32'd0);
        check("mid_rst_count",   o_cycle_count, 32'd0);
        check("mid_rst_enable",  32'(o_enable), 32'd0);
        check("mid_rst_start",   32'(o_flag_start_pc), 32'd0);
        check("mid_rst_load_pc", 32'(o_flag_load_pc), 32'd1);
        check("mid_rst_ready",   32'(o_cmd_ready), 32'd1);
        step();
        check("post_rst_count", o_cycle_count, 32'd0);
        check("post_rst_state", 32'(o_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
